// File: rtl/cla32_stream_accumulator.sv
// rtl/cla32_stream_accumulator.sv - packet running-sum sequencer around an external 32-bit CLA adder
// Sums each last-flagged input packet and presents total, carry count and beat count on a valid/ready port.
module cla32_stream_accumulator #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_sat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_live;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_carries;
  logic [CNT_W-1:0] r_beats;
  logic             r_sat;
  logic [WIDTH-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_carries;
  logic [CNT_W-1:0] r_out_beats;
  logic             r_out_sat;

  logic             w_accept;
  logic             w_first;
  logic [CNT_W-1:0] w_beats_nxt;
  logic [CNT_W-1:0] w_carries_nxt;
  logic             w_sat_nxt;

  // in_ready stays low until the first clock edge after reset release
  assign in_ready    = r_live && (r_state != S_HOLD);
  assign w_accept    = in_valid && in_ready;
  assign w_first     = (r_state == S_IDLE);

  assign add_a       = w_first ? '0 : r_acc;
  assign add_b       = in_data;
  assign add_cin     = 1'b0;

  assign out_valid   = (r_state == S_HOLD);
  assign out_sum     = r_out_sum;
  assign out_carries = r_out_carries;
  assign out_beats   = r_out_beats;
  assign out_sat     = r_out_sat;

  always_comb begin
    w_beats_nxt   = r_beats;
    w_carries_nxt = r_carries;
    w_sat_nxt     = r_sat;
    if (w_first) begin
      w_beats_nxt   = CNT_ONE;
      w_carries_nxt = add_cout ? CNT_ONE : '0;
      w_sat_nxt     = 1'b0;
    end else begin
      if (r_beats != CNT_MAX) begin
        w_beats_nxt = r_beats + CNT_ONE;
      end
      if (add_cout && (r_carries != CNT_MAX)) begin
        w_carries_nxt = r_carries + CNT_ONE;
      end
      w_sat_nxt = r_sat || (r_beats == CNT_MAX) || (add_cout && (r_carries == CNT_MAX));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept && in_last) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_carries     <= '0;
      r_beats       <= '0;
      r_sat         <= 1'b0;
      r_out_sum     <= '0;
      r_out_carries <= '0;
      r_out_beats   <= '0;
      r_out_sat     <= 1'b0;
    end else if (w_accept) begin
      r_acc     <= add_sum;
      r_carries <= w_carries_nxt;
      r_beats   <= w_beats_nxt;
      r_sat     <= w_sat_nxt;
      if (in_last) begin
        r_out_sum     <= add_sum;
        r_out_carries <= w_carries_nxt;
        r_out_beats   <= w_beats_nxt;
        r_out_sat     <= w_sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cla32_stream_accumulator.sv
// tb/tb_cla32_stream_accumulator.sv - randomized self-checking bench with packet-level reference model
module tb_cla32_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_carries;
  logic [7:0]  out_beats;
  logic        out_sat;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  cla32_stream_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carries(out_carries), .out_beats(out_beats), .out_sat(out_sat)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Packet-level model: exact 64-bit running total, results derived once per packet
  logic        m_live, m_hold;
  logic [63:0] m_total;
  int          m_n;
  logic [31:0] e_sum;
  logic [7:0]  e_car, e_beats;
  logic        e_sat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live <= 1'b0; m_hold <= 1'b0; m_total <= 64'd0; m_n <= 0;
      e_sum <= 32'd0; e_car <= 8'd0; e_beats <= 8'd0; e_sat <= 1'b0;
    end else begin
      m_live <= 1'b1;
      if (m_live && !m_hold && in_valid) begin
        logic [63:0] tot;
        logic [63:0] wraps;
        tot   = m_total + {32'd0, in_data};
        wraps = tot >> 32;
        if (in_last) begin
          e_sum   <= tot[31:0];
          e_car   <= (wraps > 64'd255) ? 8'd255 : wraps[7:0];
          e_beats <= (m_n + 1 > 255) ? 8'd255 : 8'(m_n + 1);
          e_sat   <= (m_n + 1 > 255) || (wraps > 64'd255);
          m_hold  <= 1'b1;
          m_total <= 64'd0;
          m_n     <= 0;
        end else begin
          m_total <= tot;
          m_n     <= m_n + 1;
        end
      end else if (m_hold && out_ready) begin
        m_hold <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, m_live && !m_hold);
      chk("out_valid", out_valid, m_hold);
      chk("add_cin", add_cin, 1'b0);
      chk("add_b", add_b, in_data);
      if (m_live && !m_hold) chk("add_a", add_a, (m_n == 0) ? 32'd0 : m_total[31:0]);
      chk("out_sum", out_sum, e_sum);
      chk("out_carries", out_carries, e_car);
      chk("out_beats", out_beats, e_beats);
      chk("out_sat", out_sat, e_sat);
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l, input int bubbles);
    int t;
    in_valid = 1'b1; in_data = d; in_last = l; t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin timeout("send_word"); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = $urandom;
    repeat (bubbles) begin @(posedge clk); #1; end
  endtask

  task automatic wait_result();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      t++;
      if (t > 20) begin timeout("wait_result"); break; end
    end
  endtask

  task automatic release_result(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single word
    send_word(32'h5, 1'b1, 0);
    wait_result();
    chk("single_sum", out_sum, 32'h5);
    chk("single_car", out_carries, 8'd0);
    chk("single_beats", out_beats, 8'd1);
    release_result(0);

    // carry
    send_word(32'hFFFF_FFFF, 1'b0, 0);
    send_word(32'h0000_0002, 1'b1, 0);
    wait_result();
    chk("carry_sum", out_sum, 32'h1);
    chk("carry_car", out_carries, 8'd1);
    chk("carry_beats", out_beats, 8'd2);

    // backpressure with a word offered during HOLD
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_sum_stable", out_sum, 32'h1);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_valid", out_valid, 1'b0);
    chk("bp_idle_ready", in_ready, 1'b1);

    // bubbles, then back-to-back packet
    send_word(32'd1, 1'b0, 2);
    send_word(32'd2, 1'b0, 2);
    send_word(32'd3, 1'b1, 0);
    wait_result();
    chk("bubble_sum", out_sum, 32'd6);
    chk("bubble_beats", out_beats, 8'd3);
    release_result(1);
    send_word(32'd4, 1'b1, 0);
    wait_result();
    chk("b2b_sum", out_sum, 32'd4);
    chk("b2b_beats", out_beats, 8'd1);
    release_result(0);

    // saturation
    for (int i = 0; i < 300; i++) send_word(32'hFFFF_FFFF, (i == 299), 0);
    wait_result();
    chk("sat_sum", out_sum, 32'hFFFF_FED4);
    chk("sat_beats", out_beats, 8'd255);
    chk("sat_car", out_carries, 8'd255);
    chk("sat_flag", out_sat, 1'b1);
    release_result(2);

    // randomized packets
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int w = 0; w < len; w++) begin
        logic [31:0] d;
        d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 15) : $urandom;
        send_word(d, (w == len - 1), $urandom_range(0, 2));
      end
      wait_result();
      release_result($urandom_range(0, 3));
    end

    // reset mid-packet
    send_word(32'h10, 1'b0, 0);
    send_word(32'h20, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midpkt_out_valid", out_valid, 1'b0);
    chk("midpkt_in_ready", in_ready, 1'b0);
    chk("midpkt_out_sum", out_sum, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_sum", out_sum, 32'd0);
    chk("rel_out_beats", out_beats, 8'd0);

    // reset during HOLD
    @(posedge clk); #1;
    send_word(32'h7, 1'b1, 0);
    wait_result();
    chk("hold_sum", out_sum, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", out_valid, 1'b0);
    chk("hold_rst_sum", out_sum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
